// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the OCI debug-memory controller: FSM states,
// jdo field positions and default bus widths.
package cpu_debug_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_RD_DATA,
        J_WR,
        C_RD,
        C_RD_DATA,
        C_WR_ACK
    } ocimem_state_e;

endpackage

// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// JTAG-monitor and Avalon-MM slave signal bundle of the debug-memory controller.
interface cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = cpu_debug_pkg::DEF_ADDR_W,
    parameter int DATA_W = cpu_debug_pkg::DEF_DATA_W
);
    logic [cpu_debug_pkg::JDO_W-1:0] jdo;
    logic                            take_action_ocimem_a;
    logic                            take_no_action_ocimem_a;
    logic                            take_action_ocimem_b;
    logic [ADDR_W-1:0]               avs_address;
    logic                            avs_read;
    logic                            avs_write;
    logic [DATA_W-1:0]               avs_writedata;
    logic [DATA_W/8-1:0]             avs_byteenable;
    logic [DATA_W-1:0]               avs_readdata;
    logic                            avs_waitrequest;
    logic [DATA_W-1:0]               MonDReg;
    logic [ADDR_W-1:0]               MonAReg;
    logic                            monitor_ready;
    logic                            monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest, MonDReg, MonAReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest, MonDReg, MonAReg, monitor_ready, monitor_error
    );

endinterface

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port byte-enabled RAM with registered read data (old data on a
// same-address write), kept separate so a vendor RAM primitive can drop in.
module cpu_debug_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Arbitrates JTAG monitor commands and CPU Avalon accesses onto the shared
// debug RAM and maintains the MonAReg/MonDReg/ready/error monitor state.
module cpu_debug_ocimem_ctrl
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int JTAG_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_debug_ocimem_ctrl_if.slave  io_bus
);

    ocimem_state_e       r_state;
    ocimem_state_e       w_state_next;
    logic                r_pend_valid;
    logic                r_pend_wr;
    logic [ADDR_W-1:0]   r_mon_addr;
    logic [DATA_W-1:0]   r_mon_data;
    logic [DATA_W-1:0]   r_avs_rdata;
    logic                r_ready;
    logic                r_error;

    logic                w_cmd_rd;
    logic                w_cmd_wr;
    logic                w_cmd;
    logic                w_j_busy;
    logic                w_cmd_new;
    logic                w_cmd_drop;
    logic                w_jreq;
    logic                w_jreq_wr;
    logic                w_cpu_req;
    logic                w_jtag_take;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W/8-1:0] w_ram_be;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_q;
    logic                w_waitreq;
    logic                w_unused_jdo;

    assign w_cmd_rd   = (io_bus.take_action_ocimem_a || io_bus.take_no_action_ocimem_a)
                        && io_bus.jdo[JDO_RD_BIT];
    assign w_cmd_wr   = io_bus.take_action_ocimem_b;
    assign w_cmd      = w_cmd_rd || w_cmd_wr;
    // The single pending slot plus the JTAG execution states form the "busy" window.
    assign w_j_busy   = r_pend_valid || (r_state inside {J_RD, J_RD_DATA, J_WR});
    assign w_cmd_new  = w_cmd && !w_j_busy;
    assign w_cmd_drop = w_cmd && w_j_busy;
    assign w_jreq     = r_pend_valid || w_cmd_new;
    assign w_jreq_wr  = r_pend_valid ? r_pend_wr : w_cmd_wr;
    assign w_cpu_req  = io_bus.avs_read || io_bus.avs_write;
    assign w_unused_jdo = &{1'b0, io_bus.jdo[JDO_W-1:JDO_RD_BIT+1], io_bus.jdo[JDO_ADDR_LSB-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_jtag_take  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_jreq && ((JTAG_PRIORITY != 0) || !w_cpu_req)) begin
                    w_state_next = w_jreq_wr ? J_WR : J_RD;
                    w_jtag_take  = 1'b1;
                end else if (io_bus.avs_read) begin
                    w_state_next = C_RD;
                end else if (io_bus.avs_write) begin
                    w_state_next = C_WR_ACK;
                end
            end
            J_RD:      w_state_next = J_RD_DATA;
            // The RAM port is free here, so a waiting CPU request is launched directly.
            J_RD_DATA: begin
                if (io_bus.avs_read) begin
                    w_state_next = C_RD;
                end else if (io_bus.avs_write) begin
                    w_state_next = C_WR_ACK;
                end else begin
                    w_state_next = IDLE;
                end
            end
            C_RD:      w_state_next = C_RD_DATA;
            default:   w_state_next = IDLE;
        endcase
    end

    // Outside the JTAG states the RAM reads the CPU address, so C_RD already sees q.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = io_bus.avs_address;
        w_ram_be    = io_bus.avs_byteenable;
        w_ram_wdata = io_bus.avs_writedata;
        w_waitreq   = 1'b1;
        case (r_state)
            J_RD: w_ram_addr = r_mon_addr;
            J_WR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_mon_addr;
                w_ram_be    = '1;
                w_ram_wdata = r_mon_data;
            end
            C_RD_DATA: w_waitreq = 1'b0;
            C_WR_ACK: begin
                w_ram_we  = 1'b1;
                w_waitreq = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_wr    <= 1'b0;
        end else if (w_jtag_take) begin
            r_pend_valid <= 1'b0;
        end else if (w_cmd_new) begin
            r_pend_valid <= 1'b1;
            r_pend_wr    <= w_cmd_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_addr  <= '0;
            r_mon_data  <= '0;
            r_avs_rdata <= '0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            if (io_bus.take_action_ocimem_a) begin
                r_mon_addr <= io_bus.jdo[JDO_ADDR_LSB +: ADDR_W];
            end else if (r_state == J_RD_DATA || r_state == J_WR) begin
                r_mon_addr <= r_mon_addr + 1'b1;
            end
            if (w_cmd_new && w_cmd_wr) begin
                r_mon_data <= io_bus.jdo[JDO_DATA_LSB +: DATA_W];
            end else if (r_state == J_RD_DATA) begin
                r_mon_data <= w_ram_q;
            end
            if (r_state == J_RD_DATA || r_state == J_WR) begin
                r_ready <= 1'b1;
            end
            if (w_cmd_new) begin
                r_ready <= 1'b0;
            end
            if (io_bus.take_action_ocimem_a) begin
                r_error <= 1'b0;
            end
            if (w_cmd_drop) begin
                r_error <= 1'b1;
            end
            if (r_state == C_RD) begin
                r_avs_rdata <= w_ram_q;
            end
        end
    end

    cpu_debug_ocimem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    assign io_bus.avs_readdata    = r_avs_rdata;
    assign io_bus.avs_waitrequest = w_waitreq;
    assign io_bus.MonDReg         = r_mon_data;
    assign io_bus.MonAReg         = r_mon_addr;
    assign io_bus.monitor_ready   = r_ready;
    assign io_bus.monitor_error   = r_error;

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Directed plus randomized bench for cpu_debug_ocimem_ctrl against a
// word-array model of the debug RAM and the monitor registers.
module tb_cpu_debug_ocimem_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] m_mem [256];
    logic [7:0]  m_addr;
    logic [31:0] m_dreg;
    logic        m_err;

    cpu_debug_ocimem_ctrl_if bus_if ();

    cpu_debug_ocimem_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("[TB] check %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    endtask

    task automatic check_mon(input string tag);
        check({tag, "_areg"}, 32'(bus_if.MonAReg), 32'(m_addr));
        check({tag, "_dreg"}, bus_if.MonDReg, m_dreg);
        check({tag, "_err"}, 32'(bus_if.monitor_error), 32'(m_err));
        check({tag, "_rdy"}, 32'(bus_if.monitor_ready), 32'd1);
    endtask

    // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b; exp_lat 0 = no command queued
    task automatic jtag_cmd(input int kind, input logic [37:0] word, input int exp_lat, input string tag);
        int lat;
        bus_if.jdo = word;
        bus_if.take_action_ocimem_a    = (kind == 0);
        bus_if.take_no_action_ocimem_a = (kind == 1);
        bus_if.take_action_ocimem_b    = (kind == 2);
        tick();
        bus_if.take_action_ocimem_a    = 1'b0;
        bus_if.take_no_action_ocimem_a = 1'b0;
        bus_if.take_action_ocimem_b    = 1'b0;
        if (exp_lat == 0) begin
            check({tag, "_idle_rdy"}, 32'(bus_if.monitor_ready), 32'd1);
        end else begin
            check({tag, "_busy"}, 32'(bus_if.monitor_ready), 32'd0);
            lat = 1;
            while (!bus_if.monitor_ready && lat < 20) begin
                tick();
                lat++;
            end
            check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic rd, input string tag);
        logic [37:0] w;
        w = 38'(a) << 2;
        w[34:10] = 25'($urandom);
        w[35] = rd;
        w[37:36] = 2'($urandom);
        w[1:0] = 2'($urandom);
        jtag_cmd(0, w, rd ? 3 : 0, tag);
        m_err = 1'b0;
        if (rd) begin
            m_dreg = m_mem[a];
            m_addr = 8'((int'(a) + 1) % 256);
        end else begin
            m_addr = a;
        end
        check_mon(tag);
    endtask

    task automatic jtag_write(input logic [31:0] d, input string tag);
        jtag_cmd(2, {2'($urandom), 1'b0, d, 3'($urandom)}, 2, tag);
        m_mem[m_addr] = d;
        m_dreg = d;
        m_addr = 8'((int'(m_addr) + 1) % 256);
        check_mon(tag);
    endtask

    task automatic jtag_read_here(input string tag);
        jtag_cmd(1, {2'($urandom), 1'b1, 35'($urandom)}, 3, tag);
        m_dreg = m_mem[m_addr];
        m_addr = 8'((int'(m_addr) + 1) % 256);
        check_mon(tag);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
        int k;
        bus_if.avs_address = a;
        bus_if.avs_writedata = d;
        bus_if.avs_byteenable = be;
        bus_if.avs_write = 1'b1;
        k = 1;
        while (bus_if.avs_waitrequest && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'd2);
        tick();
        bus_if.avs_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic cpu_read(input logic [7:0] a, input string tag);
        int k;
        bus_if.avs_address = a;
        bus_if.avs_read = 1'b1;
        k = 1;
        while (bus_if.avs_waitrequest && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'd3);
        check({tag, "_data"}, bus_if.avs_readdata, m_mem[a]);
        tick();
        bus_if.avs_read = 1'b0;
    endtask

    initial begin
        int k_rdy;
        int k_ack;
        logic [31:0] rd_obs;
        logic [31:0] val_a;

        bus_if.jdo = '0;
        bus_if.take_action_ocimem_a = 1'b0;
        bus_if.take_no_action_ocimem_a = 1'b0;
        bus_if.take_action_ocimem_b = 1'b0;
        bus_if.avs_address = '0;
        bus_if.avs_read = 1'b0;
        bus_if.avs_write = 1'b0;
        bus_if.avs_writedata = '0;
        bus_if.avs_byteenable = '0;
        m_addr = '0;
        m_dreg = '0;
        m_err = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_waitreq", 32'(bus_if.avs_waitrequest), 32'd1);
        check("rst_rdata", bus_if.avs_readdata, 32'd0);
        check_mon("rst");
        reset = 1'b0;
        tick();

        // Fill the whole RAM through JTAG; auto-increment wraps back to 0
        jtag_load(8'h00, 1'b0, "init_ld");
        for (int i = 0; i < 256; i++) jtag_write($urandom, "init_wr");
        check("init_wrap", 32'(bus_if.MonAReg), 32'h0);

        // JTAG write then JTAG read back at 0x10
        jtag_load(8'h10, 1'b0, "tp1_ld");
        jtag_write(32'hDEADBEEF, "tp1_wr");
        check("tp1_areg_const", 32'(bus_if.MonAReg), 32'h11);
        cpu_read(8'h10, "tp1_crd");
        jtag_load(8'h10, 1'b1, "tp2_rd");
        check("tp2_dreg_const", bus_if.MonDReg, 32'hDEADBEEF);

        // no_action_a without the read bit is a no-op
        jtag_cmd(1, 38'h0, 0, "nop");
        check_mon("nop");

        // Partial CPU write at the top address, then JTAG read wraps MonAReg
        jtag_load(8'hFF, 1'b0, "tp3_ld");
        jtag_write(32'h0, "tp3_clr");
        cpu_write(8'hFF, 32'h12345678, 4'h3, "tp3_cwr");
        jtag_load(8'hFF, 1'b1, "tp3_rd");
        check("tp3_dreg_const", bus_if.MonDReg, 32'h00005678);
        check("tp3_wrap", 32'(bus_if.MonAReg), 32'h0);

        // Same-cycle JTAG read and CPU read; JTAG wins
        jtag_load(8'h20, 1'b0, "tp4_ld");
        bus_if.jdo = 38'h1 << 35;
        bus_if.take_no_action_ocimem_a = 1'b1;
        bus_if.avs_address = 8'h30;
        bus_if.avs_read = 1'b1;
        k_rdy = 0;
        k_ack = 0;
        rd_obs = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) bus_if.take_no_action_ocimem_a = 1'b0;
            if (k_rdy == 0 && k > 1 && bus_if.monitor_ready) k_rdy = k;
            if (!bus_if.avs_waitrequest) begin
                k_ack = k;
                rd_obs = bus_if.avs_readdata;
                break;
            end
            tick();
        end
        tick();
        bus_if.avs_read = 1'b0;
        bus_if.take_no_action_ocimem_a = 1'b0;
        check("tp4_jtag_lat", 32'(k_rdy), 32'd4);
        check("tp4_cpu_lat", 32'(k_ack), 32'd5);
        check("tp4_cpu_data", rd_obs, m_mem[8'h30]);
        m_dreg = m_mem[8'h20];
        m_addr = 8'h21;
        check_mon("tp4");

        // Back-to-back ocimem_b: second dropped, error sticky until ocimem_a
        jtag_load(8'h40, 1'b0, "tp5_ld");
        val_a = $urandom;
        bus_if.jdo = {2'b00, 1'b0, val_a, 3'b000};
        bus_if.take_action_ocimem_b = 1'b1;
        tick();
        bus_if.jdo = {2'b00, 1'b0, ~val_a, 3'b000};
        tick();
        bus_if.take_action_ocimem_b = 1'b0;
        m_mem[8'h40] = val_a;
        m_dreg = val_a;
        m_addr = 8'h41;
        m_err = 1'b1;
        check_mon("tp5_drop");
        cpu_read(8'h40, "tp5_crd40");
        cpu_read(8'h41, "tp5_crd41");
        jtag_read_here("tp5_sticky");
        jtag_load(8'h50, 1'b0, "tp5_clr");

        // Reset while the CPU read sits in C_RD
        bus_if.avs_address = 8'h40;
        bus_if.avs_read = 1'b1;
        tick();
        check("tp6_crd_wait", 32'(bus_if.avs_waitrequest), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.avs_read = 1'b0;
        m_addr = '0;
        m_dreg = '0;
        m_err = 1'b0;
        check("tp6_waitreq", 32'(bus_if.avs_waitrequest), 32'd1);
        check("tp6_rdata", bus_if.avs_readdata, 32'd0);
        check_mon("tp6");
        tick();
        cpu_read(8'h40, "tp6_crd");
        jtag_read_here("tp6_jrd");

        // Randomized mix against the model
        for (int it = 0; it < 40; it++) begin
            int          op;
            logic [7:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 4);
            a = 8'($urandom);
            d = $urandom;
            case (op)
                0: begin
                    jtag_load(a, 1'b0, "rnd_ld");
                    jtag_write(d, "rnd_jwr");
                end
                1: jtag_load(a, 1'b1, "rnd_jrd");
                2: jtag_read_here("rnd_jna");
                3: cpu_write(a, d, 4'($urandom), "rnd_cwr");
                default: cpu_read(a, "rnd_crd");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
